// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: host-loaded program RAM that issues instructions to the cpu.
// Each instruction is offered with a one-cycle load pulse, then a one-cycle s pulse,
// then the sequencer waits for a rising edge on cpu_w (or a timeout) before moving on.
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-low reset
//   wr_en/addr/data  program RAM write port, accepted only while idle
//   prog_len         number of instructions to run, sampled on start (clamped to DEPTH)
//   start            begin a run at address 0, accepted only while idle
//   cpu_w            cpu wait/idle flag; its rising edge completes an instruction
//   cpu_in/load/s    instruction word and handshake strobes to the cpu
//   pc               index of the current instruction
//   busy/done/err    not-idle flag, end-of-run pulse, sticky timeout flag
module cpu_instr_sequencer #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned AW      = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          cpu_w,
   output logic [15:0]   cpu_in,
   output logic          cpu_load,
   output logic          cpu_s,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic          err
);

   localparam int unsigned TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_GO, S_WAIT, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [15:0]   mem [DEPTH];
   logic          w_q;
   logic          w_rise;
   logic          wr_ok;
   logic [AW:0]   len_q, len_nxt;
   logic [TW-1:0] tmo_cnt, tmo_nxt;
   logic [AW-1:0] pc_nxt;
   logic [15:0]   cpu_in_nxt;
   logic          err_nxt;

   assign w_rise = cpu_w & ~w_q;
   assign wr_ok  = wr_en && (state == S_IDLE);

   // Program RAM: not reset, written only while idle.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_addr] <= wr_data;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         w_q      <= 1'b0;
         len_q    <= '0;
         tmo_cnt  <= '0;
         cpu_in   <= '0;
         cpu_load <= 1'b0;
         cpu_s    <= 1'b0;
         pc       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         w_q      <= cpu_w;
         len_q    <= len_nxt;
         tmo_cnt  <= tmo_nxt;
         cpu_in   <= cpu_in_nxt;
         cpu_load <= (state_nxt == S_LOAD);
         cpu_s    <= (state_nxt == S_GO);
         pc       <= pc_nxt;
         busy     <= (state_nxt != S_IDLE);
         done     <= (state_nxt == S_DONE);
         err      <= err_nxt;
      end
   end

   // Next-state and next-output logic; outputs reflect the state being entered.
   always_comb begin
      state_nxt  = state;
      len_nxt    = len_q;
      tmo_nxt    = tmo_cnt;
      pc_nxt     = pc;
      err_nxt    = err;
      cpu_in_nxt = cpu_in;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               len_nxt   = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
               pc_nxt    = '0;
               err_nxt   = 1'b0;
               state_nxt = (prog_len == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: state_nxt = S_GO;
         S_GO: begin
            tmo_nxt   = '0;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            tmo_nxt = tmo_cnt + TW'(1);
            // A completion edge wins over a timeout in the same cycle.
            if (w_rise) begin
               if ({1'b0, pc} == (len_q - (AW+1)'(1))) begin
                  state_nxt = S_DONE;
               end else begin
                  pc_nxt    = pc + AW'(1);
                  state_nxt = S_LOAD;
               end
            end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               state_nxt = S_DONE;
            end
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // Fetch for the next LOAD; forward a same-cycle write so it lands before the read.
      if (state_nxt == S_LOAD) begin
         cpu_in_nxt = (wr_ok && (wr_addr == pc_nxt)) ? wr_data : mem[pc_nxt];
      end
   end

endmodule
